// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL power-up / recovery reset sequencer
//
// Runs on the free-running PLL reference clock. Pulses the PLL reset, waits
// for lock (with timeout and retry), requires lock to hold for a stable
// window, then drops the downstream reset request. Loss of lock in RUN or a
// soft request sends the sequence back to the PLL reset pulse.
//
// Ports:
//   clk          free-running reference clock
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock indicator, asynchronous to clk
//   soft_reset   single-cycle request to re-sequence the PLL
//   pll_rst      active-high PLL reset
//   sys_rst      active-high reset request to sys_clk/sdr_clk domains
//   ready        high only while in RUN
//   state        0 RESET_PLL, 1 WAIT_LOCK, 2 STABILISE, 3 RUN
//   retry_count  number of lock timeouts, saturating at 15
//   lock_timeout sticky: a lock timeout has occurred
//   lock_lost    sticky: lock dropped while in RUN

module pll_reset_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic       lock_timeout,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILISE = 3'd2,
    ST_RUN       = 3'd3
  } state_e;

  // Terminal counter values: the counter starts at 0 on state entry, so a
  // dwell of N cycles ends when it reads N-1.
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  // Lock synchroniser
  logic sync_meta_d, sync_meta_q;
  logic locked_s_d, locked_s_q;

  // Sequencer state
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [3:0]       retry_d, retry_q;
  logic             lock_timeout_d, lock_timeout_q;
  logic             lock_lost_d, lock_lost_q;

  // Registered outputs
  logic pll_rst_d, pll_rst_q;
  logic sys_rst_d, sys_rst_q;
  logic ready_d, ready_q;

  // Two-flop synchroniser; every decision below uses locked_s_q only.
  always_comb begin
    sync_meta_d = pll_locked;
    locked_s_d  = sync_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      locked_s_q  <= locked_s_d;
    end
  end

  // Next-state, counter, status and output decode
  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    lock_timeout_d = lock_timeout_q;
    lock_lost_d    = lock_lost_q;
    cnt_d          = cnt_q + CNT_W'(1);

    if (soft_reset) begin
      // Highest priority; in RESET_PLL this just restarts the pulse.
      state_d = ST_RESET_PLL;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RESET_LAST) begin
            state_d = ST_WAIT_LOCK;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock beats a coincident timeout, so no retry is counted then.
          if (locked_s_q) begin
            state_d = ST_STABILISE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d        = ST_RESET_PLL;
            lock_timeout_d = 1'b1;
            if (retry_q != 4'hF) begin
              retry_d = retry_q + 4'd1;
            end
          end
        end

        ST_STABILISE: begin
          // A drop even on the terminal cycle falls back to WAIT_LOCK,
          // which reopens a fresh timeout window without counting a retry.
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (!locked_s_q) begin
            state_d     = ST_RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_RESET_PLL;
        end
      endcase
    end

    // Counter restarts on every transition and on any soft request.
    if (soft_reset || (state_d != state_q)) begin
      cnt_d = '0;
    end

    // Outputs decode the next state so they move in the same cycle as state.
    pll_rst_d = (state_d == ST_RESET_PLL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RESET_PLL;
      cnt_q          <= '0;
      retry_q        <= 4'd0;
      lock_timeout_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      pll_rst_q      <= 1'b1;
      sys_rst_q      <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      lock_timeout_q <= lock_timeout_d;
      lock_lost_q    <= lock_lost_d;
      pll_rst_q      <= pll_rst_d;
      sys_rst_q      <= sys_rst_d;
      ready_q        <= ready_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign ready        = ready_q;
  assign state        = state_q;
  assign retry_count  = retry_q;
  assign lock_timeout = lock_timeout_q;
  assign lock_lost    = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int LT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic       lock_timeout;
  logic       lock_lost;

  pll_reset_sequencer #(
    .RESET_CYCLES (RC),
    .STABLE_CYCLES(SC),
    .LOCK_TIMEOUT (LT),
    .CNT_W        (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_reset  (soft_reset),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .state       (state),
    .retry_count (retry_count),
    .lock_timeout(lock_timeout),
    .lock_lost   (lock_lost)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_cycles = 0;

  // Behavioural model: phase (0..3) and dwell time in that phase.
  int m_phase = 0;
  int m_dwell = 0;
  int m_retry = 0;
  bit m_tmo = 1'b0;
  bit m_lost = 1'b0;
  bit lk_hist[$];
  bit m_ls;

  task automatic go(input int p);
    m_phase = p;
    m_dwell = 0;
  endtask

  task automatic model_step(input bit ls);
    if (soft_reset) go(0);
    else if (m_phase == 0 && m_dwell == RC - 1) go(1);
    else if (m_phase == 1 && ls) go(2);
    else if (m_phase == 1 && m_dwell == LT - 1) begin
      go(0);
      m_tmo = 1'b1;
      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    end
    else if (m_phase == 2 && !ls) go(1);
    else if (m_phase == 2 && m_dwell == SC - 1) go(3);
    else if (m_phase == 3 && !ls) begin
      go(0);
      m_lost = 1'b1;
    end
    else m_dwell++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_dwell = 0;
      m_retry = 0;
      m_tmo = 1'b0;
      m_lost = 1'b0;
      lk_hist.delete();
    end else begin
      // Lock is seen two samples late.
      m_ls = (lk_hist.size() == 2) ? lk_hist[0] : 1'b0;
      lk_hist.push_back(pll_locked);
      if (lk_hist.size() > 2) void'(lk_hist.pop_front());
      model_step(m_ls);
    end
  end

  always @(posedge clk) cyc++;

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    int e_st;
    e_st = m_phase;
    if (ready) ready_cycles++;
    vectors++;
    if (int'(state) != e_st || pll_rst != (e_st == 0) || sys_rst != (e_st != 3) ||
        ready != (e_st == 3) || int'(retry_count) != m_retry ||
        lock_timeout != m_tmo || lock_lost != m_lost) begin
      miscompares++;
      $display("FAIL model cycle %0d: got st=%0d prst=%0b srst=%0b rdy=%0b retry=%0d tmo=%0b lost=%0b; required st=%0d prst=%0b srst=%0b rdy=%0b retry=%0d tmo=%0b lost=%0b",
               cyc, state, pll_rst, sys_rst, ready, retry_count, lock_timeout, lock_lost,
               e_st, e_st == 0, e_st != 3, e_st == 3, m_retry, m_tmo, m_lost);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input int tgt, input int maxc, input string nm);
    int n;
    n = 0;
    while (int'(state) != tgt && n < maxc) begin
      tick(1);
      n++;
    end
    check(nm, int'(state), tgt);
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    while (pll_rst && n < 50) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int rises;
    bit prev;
    int rc_snap;

    // 1: lock present from the start
    rst_n = 1'b0;
    pll_locked = 1'b1;
    tick(3);
    check("reset_state", int'(state), 0);
    check("reset_pll_rst", int'(pll_rst), 1);
    check("reset_sys_rst", int'(sys_rst), 1);
    rst_n = 1'b1;
    pulse_len(n);
    check("t1_pulse_len", n, 4);
    n = 0;
    while (!ready && n < 50) begin
      tick(1);
      n++;
    end
    check("t1_ready_latency", n, 9);
    check("t1_sys_rst_low", int'(sys_rst), 0);
    check("t1_retry", int'(retry_count), 0);

    // 2: lock withheld for three full attempts
    rst_n = 1'b0;
    tick(2);
    pll_locked = 1'b0;
    rst_n = 1'b1;
    rises = 0;
    prev = pll_rst;
    repeat (120) begin
      tick(1);
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
    end
    check("t2_repulses", rises, 3);
    check("t2_retry", int'(retry_count), 3);
    check("t2_timeout_flag", int'(lock_timeout), 1);
    pll_locked = 1'b1;
    wait_state(3, 60, "t2_run");

    // 4: lock drop in RUN
    pll_locked = 1'b0;
    tick(2);
    check("t4_still_run", int'(state), 3);
    tick(1);
    check("t4_state", int'(state), 0);
    check("t4_sys_rst", int'(sys_rst), 1);
    check("t4_lock_lost", int'(lock_lost), 1);

    // 3: glitchy lock never reaches RUN, short windows never time out
    tick(6);
    rc_snap = ready_cycles;
    repeat (10) begin
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick(5);
    end
    check("t3_no_run", ready_cycles - rc_snap, 0);
    check("t3_retry_same", int'(retry_count), 3);
    tick(40);
    check("t3_retry_genuine", int'(retry_count), 4);
    pll_locked = 1'b1;
    wait_state(3, 80, "t3_run");

    // 5: soft reset in RUN, then on the cycle a timeout would fire
    soft_reset = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    soft_reset = 1'b0;
    check("t5_soft_state", int'(state), 0);
    check("t5_soft_retry", int'(retry_count), 4);
    check("t5_soft_lost", int'(lock_lost), 1);
    tick(35);
    check("t5_pre_timeout", int'(state), 1);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    check("t5_soft_vs_tmo", int'(state), 0);
    check("t5_no_retry", int'(retry_count), 4);
    // soft request mid-pulse restarts the 4-cycle count
    tick(2);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    pulse_len(n);
    check("t5_extended_pulse", n, 4);

    // 6: asynchronous reset mid-STABILISE
    pll_locked = 1'b1;
    wait_state(2, 60, "t6_stabilise");
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_state", int'(state), 0);
    check("t6_async_pll_rst", int'(pll_rst), 1);
    check("t6_async_sys_rst", int'(sys_rst), 1);
    check("t6_async_ready", int'(ready), 0);
    check("t6_async_retry", int'(retry_count), 0);
    check("t6_async_flags", int'({lock_timeout, lock_lost}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_len(n);
    check("t6_pulse_len", n, 4);
    wait_state(3, 40, "t6_run");
    check("t6_retry", int'(retry_count), 0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
